// File: rtl/store_arbiter.sv
// ---------------------------------------------------------------------------
// store_arbiter
//
// Four requesters share one 32-bit accumulator. A round-robin arbiter picks
// one pending requester. Its increment is latched and added to the
// accumulator. The requester then gets a one-cycle ack pulse. Each service
// runs IDLE -> GRANT -> ACK -> IDLE.
//
// Ports
//   clock    in   single clock, rising-edge
//   clear_n  in   asynchronous active-low reset
//   req      in   [NREQ]          per-requester request, held until ack
//   step     in   [NREQ*STEP_W]   packed increments, requester i at i*STEP_W
//   zero     in   synchronous accumulator clear, honoured only in IDLE
//   grant    out  [NREQ]          one-hot, requester being served
//   ack      out  [NREQ]          one-hot completion pulse
//   store    out  [32]            accumulator value
//   wrap     out  one-cycle pulse, last addition carried out of bit 31
//   busy     out  high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module store_arbiter #(
   parameter int NREQ   = 4,
   parameter int STEP_W = 8
) (
   input  logic                     clock,
   input  logic                     clear_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*STEP_W-1:0]   step,
   input  logic                     zero,
   output logic [NREQ-1:0]          grant,
   output logic [NREQ-1:0]          ack,
   output logic [31:0]              store,
   output logic                     wrap,
   output logic                     busy
);

   localparam int PTR_W = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      ACK
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [31:0]         store_q, store_d;
   logic [NREQ-1:0]     grant_q, grant_d;
   logic [NREQ-1:0]     ack_q, ack_d;
   logic                wrap_q, wrap_d;
   logic [STEP_W-1:0]   stepLat_q, stepLat_d;

   logic                found;
   logic [PTR_W-1:0]    winner;
   logic [PTR_W-1:0]    idx;
   logic [32:0]         sum;

   // Round-robin search starting at ptr_q. The index wraps naturally because
   // it is PTR_W bits wide. The first asserted request wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = ptr_q + PTR_W'(k);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // 33-bit sum so that the carry out of bit 31 becomes the wrap pulse.
   assign sum = {1'b0, store_q} + {{(33-STEP_W){1'b0}}, stepLat_q};

   // Next-state and output logic. grant, ack and wrap default to zero.
   // Each of them is therefore high for exactly the one cycle in which it is
   // produced.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      store_d   = store_q;
      grant_d   = '0;
      ack_d     = '0;
      wrap_d    = 1'b0;
      stepLat_d = stepLat_q;
      case (state_q)
         IDLE: begin
            if (zero) begin
               store_d = '0;
            end else if (found) begin
               state_d   = GRANT;
               grant_d   = {{(NREQ-1){1'b0}}, 1'b1} << winner;
               stepLat_d = step[winner*STEP_W +: STEP_W];
               ptr_d     = winner + PTR_W'(1);
            end
         end
         GRANT: begin
            state_d = ACK;
            store_d = sum[31:0];
            ack_d   = grant_q;
            wrap_d  = sum[32];
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers. Reset abandons any service in flight.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         store_q   <= '0;
         grant_q   <= '0;
         ack_q     <= '0;
         wrap_q    <= 1'b0;
         stepLat_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         store_q   <= store_d;
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         wrap_q    <= wrap_d;
         stepLat_q <= stepLat_d;
      end
   end

   assign grant = grant_q;
   assign ack   = ack_q;
   assign store = store_q;
   assign wrap  = wrap_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_store_arbiter.sv
// ---------------------------------------------------------------------------
// tb_store_arbiter
//
// Directed testbench for store_arbiter. Each scenario lives in its own task
// with hand-computed expectations. Inputs are driven on the falling edge and
// outputs are sampled there too, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_store_arbiter;

   logic        clock;
   logic        clear_n;
   logic [3:0]  req;
   logic [31:0] step;
   logic        zero;
   logic [3:0]  grant;
   logic [3:0]  ack;
   logic [31:0] store;
   logic        wrap;
   logic        busy;

   int errors;
   int checks;

   store_arbiter #(.NREQ(4), .STEP_W(8)) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .req     (req),
      .step    (step),
      .zero    (zero),
      .grant   (grant),
      .ack     (ack),
      .store   (store),
      .wrap    (wrap),
      .busy    (busy)
   );

   // 10-time-unit clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and come back to the falling edge
   task automatic tick;
      @(posedge clock);
      @(negedge clock);
   endtask

   // Pulse reset across one rising edge and leave the DUT idle
   task automatic applyStimulus_reset;
      @(negedge clock);
      clear_n = 1'b0;
      req     = '0;
      zero    = 1'b0;
      step    = '0;
      @(negedge clock);
      clear_n = 1'b1;
   endtask

   // Asynchronous reset forces all outputs low without a clock edge
   task automatic test_reset;
      clear_n = 1'b1;
      req     = '0;
      zero    = 1'b0;
      step    = '0;
      #2;
      clear_n = 1'b0;
      #1;
      checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant: got %b want %b", grant, 4'b0000); end
      checks++; if (ack   !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ack: got %b want %b", ack, 4'b0000); end
      checks++; if (store !== 32'd0)   begin errors++; $display("[TB] FAIL reset_store: got %h want %h", store, 32'd0); end
      checks++; if (wrap  !== 1'b0)    begin errors++; $display("[TB] FAIL reset_wrap: got %b want 0", wrap); end
      checks++; if (busy  !== 1'b0)    begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      req = 4'b1111;
      tick();
      checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_hold_grant: got %b want %b", grant, 4'b0000); end
      req     = '0;
      clear_n = 1'b1;
   endtask

   // One requester, step 3: grant, then ack with store=3, then idle
   task automatic test_single;
      req  = 4'b0001;
      step = 32'h0000_0003;
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL single_grant: got %b want %b", grant, 4'b0001); end
      checks++; if (busy  !== 1'b1)    begin errors++; $display("[TB] FAIL single_busy: got %b want 1", busy); end
      checks++; if (ack   !== 4'b0000) begin errors++; $display("[TB] FAIL single_ack_early: got %b want %b", ack, 4'b0000); end
      tick();
      checks++; if (ack   !== 4'b0001) begin errors++; $display("[TB] FAIL single_ack: got %b want %b", ack, 4'b0001); end
      checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL single_grant_clr: got %b want %b", grant, 4'b0000); end
      checks++; if (store !== 32'd3)   begin errors++; $display("[TB] FAIL single_store: got %0d want 3", store); end
      req = 4'b0000;
      tick();
      checks++; if (busy  !== 1'b0)    begin errors++; $display("[TB] FAIL single_idle_busy: got %b want 0", busy); end
      checks++; if (ack   !== 4'b0000) begin errors++; $display("[TB] FAIL single_ack_clr: got %b want %b", ack, 4'b0000); end
   endtask

   // All four requesting with steps 1/2/4/8; service order 0,1,2,3
   task automatic test_round_robin;
      logic [3:0]  expG;
      logic [31:0] expS;
      applyStimulus_reset();
      step = {8'd8, 8'd4, 8'd2, 8'd1};
      req  = 4'b1111;
      expS = 32'd0;
      for (int i = 0; i < 4; i++) begin
         expG = 4'b0001 << i;
         expS = expS + (32'd1 << i);
         tick();
         checks++; if (grant !== expG) begin errors++; $display("[TB] FAIL rr_grant%0d: got %b want %b", i, grant, expG); end
         tick();
         checks++; if (ack !== expG) begin errors++; $display("[TB] FAIL rr_ack%0d: got %b want %b", i, ack, expG); end
         checks++; if (store !== expS) begin errors++; $display("[TB] FAIL rr_store%0d: got %0d want %0d", i, store, expS); end
         req[i] = 1'b0;
         tick();
      end
      checks++; if (store !== 32'd15) begin errors++; $display("[TB] FAIL rr_final: got %0d want 15", store); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle: got %b want 0", busy); end
   endtask

   // Requesters 0 and 2 keep re-requesting; they must alternate
   task automatic test_fairness;
      int         ord [4];
      logic [3:0] expG;
      ord = '{0, 2, 0, 2};
      applyStimulus_reset();
      step = {4{8'd1}};
      req  = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         expG = 4'b0001 << ord[i];
         tick();
         checks++; if (grant !== expG) begin errors++; $display("[TB] FAIL fair_grant%0d: got %b want %b", i, grant, expG); end
         tick();
         req[ord[i]] = 1'b0;
         tick();
         req = 4'b0101;
      end
      checks++; if (store !== 32'd4) begin errors++; $display("[TB] FAIL fair_store: got %0d want 4", store); end
   endtask

   // Accumulator preloaded near the top; step 3 wraps to 1 with a wrap pulse
   task automatic test_wrap;
      applyStimulus_reset();
      force dut.store_q = 32'hFFFF_FFFE;
      tick();
      release dut.store_q;
      checks++; if (store !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL wrap_preload: got %h want fffffffe", store); end
      req  = 4'b0001;
      step = 32'h0000_0003;
      tick();
      checks++; if (wrap !== 1'b0) begin errors++; $display("[TB] FAIL wrap_early: got %b want 0", wrap); end
      tick();
      checks++; if (store !== 32'h0000_0001) begin errors++; $display("[TB] FAIL wrap_store: got %h want 00000001", store); end
      checks++; if (wrap !== 1'b1) begin errors++; $display("[TB] FAIL wrap_pulse: got %b want 1", wrap); end
      checks++; if (ack !== 4'b0001) begin errors++; $display("[TB] FAIL wrap_ack: got %b want %b", ack, 4'b0001); end
      req = 4'b0000;
      tick();
      checks++; if (wrap !== 1'b0) begin errors++; $display("[TB] FAIL wrap_clr: got %b want 0", wrap); end
      checks++; if (store !== 32'h0000_0001) begin errors++; $display("[TB] FAIL wrap_hold: got %h want 00000001", store); end
   endtask

   // zero beats a request in IDLE and is ignored in GRANT and ACK; step is latched
   task automatic test_zero;
      applyStimulus_reset();
      req  = 4'b0010;
      step = {8'd0, 8'd0, 8'd9, 8'd0};
      tick();
      tick();
      checks++; if (store !== 32'd9) begin errors++; $display("[TB] FAIL zero_setup: got %0d want 9", store); end
      req = 4'b0000;
      tick();
      zero = 1'b1;
      req  = 4'b0010;
      tick();
      checks++; if (store !== 32'd0)   begin errors++; $display("[TB] FAIL zero_clear: got %0d want 0", store); end
      checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL zero_prio_grant: got %b want %b", grant, 4'b0000); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL zero_prio_busy: got %b want 0", busy); end
      zero = 1'b0;
      tick();
      checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL zero_then_grant: got %b want %b", grant, 4'b0010); end
      zero = 1'b1;
      step = {8'd0, 8'd0, 8'd5, 8'd0};
      tick();
      checks++; if (store !== 32'd9) begin errors++; $display("[TB] FAIL zero_in_grant: got %0d want 9", store); end
      req = 4'b0000;
      tick();
      checks++; if (store !== 32'd9) begin errors++; $display("[TB] FAIL zero_in_ack: got %0d want 9", store); end
      tick();
      checks++; if (store !== 32'd0) begin errors++; $display("[TB] FAIL zero_late_idle: got %0d want 0", store); end
      zero = 1'b0;
   endtask

   // A step of zero still runs a full service and leaves store unchanged
   task automatic test_step_zero;
      applyStimulus_reset();
      req  = 4'b0100;
      step = {8'd0, 8'd7, 8'd0, 8'd0};
      tick();
      tick();
      req = 4'b0000;
      tick();
      step = 32'd0;
      req  = 4'b0100;
      tick();
      checks++; if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL step0_grant: got %b want %b", grant, 4'b0100); end
      tick();
      checks++; if (ack !== 4'b0100) begin errors++; $display("[TB] FAIL step0_ack: got %b want %b", ack, 4'b0100); end
      checks++; if (store !== 32'd7) begin errors++; $display("[TB] FAIL step0_store: got %0d want 7", store); end
      req = 4'b0000;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL step0_idle: got %b want 0", busy); end
   endtask

   // Reset during GRANT abandons the service; pointer restarts at 0
   task automatic test_back_to_back_reset;
      applyStimulus_reset();
      req  = 4'b0001;
      step = 32'h0000_0005;
      tick();
      tick();
      checks++; if (store !== 32'd5) begin errors++; $display("[TB] FAIL rst_setup: got %0d want 5", store); end
      req = 4'b0000;
      tick();
      req = 4'b0001;
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL rst_pre_grant: got %b want %b", grant, 4'b0001); end
      clear_n = 1'b0;
      #1;
      checks++; if (store !== 32'd0)   begin errors++; $display("[TB] FAIL rst_mid_store: got %0d want 0", store); end
      checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL rst_mid_grant: got %b want %b", grant, 4'b0000); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL rst_mid_busy: got %b want 0", busy); end
      tick();
      checks++; if (ack !== 4'b0000)   begin errors++; $display("[TB] FAIL rst_mid_ack: got %b want %b", ack, 4'b0000); end
      clear_n = 1'b1;
      req  = 4'b0011;
      step = {8'd0, 8'd0, 8'd4, 8'd2};
      tick();
      checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL rst_ptr_grant: got %b want %b", grant, 4'b0001); end
      tick();
      checks++; if (store !== 32'd2)   begin errors++; $display("[TB] FAIL rst_after_store: got %0d want 2", store); end
      req = 4'b0010;
      tick();
   endtask

   // Scenario sequence
   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_fairness();
      test_wrap();
      test_zero();
      test_step_zero();
      test_back_to_back_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
